// File: rtl/dct_pkg.sv
// dct_pkg: shared types and constants for the 8x8 2D DCT scheduler.
//   DCT_N             - transform size (points per 1D pass)
//   dct_sched_state_t - scheduler FSM states
//   dct_tag_t         - tag travelling alongside each engine operation
package dct_pkg;

    localparam int DCT_N = 8;

    typedef enum logic [1:0] {
        ROW_ISSUE = 2'd0,
        ROW_DRAIN = 2'd1,
        COL_ISSUE = 2'd2
    } dct_sched_state_t;

    typedef struct packed {
        logic       vld;
        logic       pass;   // 0 = row pass, 1 = column pass
        logic [2:0] idx;
    } dct_tag_t;

    localparam logic PASS_ROW = 1'b0;
    localparam logic PASS_COL = 1'b1;

endpackage

// File: rtl/dct_tbuf.sv
// dct_tbuf: 8x8 transpose buffer of W-bit words.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low clear of all words
//   i_wr_en             - write row i_wr_row with i_wr_data (word k -> column k)
//   i_wr_row, i_wr_data - row write port
//   i_rd_col            - column select for the combinational read
//   o_rd_data           - word k = buffer[k][i_rd_col]
module dct_tbuf
    import dct_pkg::*;
#(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_en,
    input  logic [2:0]         i_wr_row,
    input  logic [DCT_N*W-1:0] i_wr_data,
    input  logic [2:0]         i_rd_col,
    output logic [DCT_N*W-1:0] o_rd_data
);

    logic [W-1:0] r_mem [DCT_N][DCT_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DCT_N; i++) begin
                for (int unsigned j = 0; j < DCT_N; j++) begin
                    r_mem[i][j] <= '0;
                end
            end
        end else if (i_wr_en) begin
            for (int unsigned k = 0; k < DCT_N; k++) begin
                r_mem[i_wr_row][k] <= i_wr_data[k*W +: W];
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int unsigned k = 0; k < DCT_N; k++) begin
            o_rd_data[k*W +: W] = r_mem[k][i_rd_col];
        end
    end

endmodule

// File: rtl/dct_2d_sched.sv
// dct_2d_sched: time-multiplexes one external 8-point 1D DCT engine over the
// row pass and column pass of an 8x8 2D DCT.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - row input handshake, in_data word k = column k
//   eng_x_in/eng_x_out  - vector to / result from the external engine
//   out_valid           - coefficient column valid (no backpressure)
//   out_data            - word k = coefficient (v=k, u=out_col)
//   out_col, out_last   - column index, high with column 7
//   busy                - block in progress
//   blk_cnt             - completed-block counter (only with DCT_2D_BLK_CNT_EN)
// Build option: define DCT_2D_BLK_CNT_EN to add the blk_cnt output.
module dct_2d_sched
    import dct_pkg::*;
#(
    parameter int W       = 16,
    parameter int DCT_LAT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DCT_N*W-1:0] in_data,
    output logic [DCT_N*W-1:0] eng_x_in,
    input  logic [DCT_N*W-1:0] eng_x_out,
    output logic               out_valid,
    output logic [DCT_N*W-1:0] out_data,
    output logic [2:0]         out_col,
    output logic               out_last,
    output logic               busy
`ifdef DCT_2D_BLK_CNT_EN
    ,
    output logic [15:0]        blk_cnt
`endif
);

    dct_sched_state_t   r_state;
    logic [2:0]         r_row_cnt;
    logic [2:0]         r_col_cnt;
    dct_tag_t           r_tag [DCT_LAT];
    logic               r_out_valid;
    logic [DCT_N*W-1:0] r_out_data;
    logic [2:0]         r_out_col;
    logic               r_out_last;

    dct_tag_t           w_tag_in;
    dct_tag_t           w_tail;
    logic               w_accept;
    logic               w_wb_en;
    logic               w_emit;
    logic               w_row7_done;
    logic [DCT_N*W-1:0] w_col_rd;

    // Reset is folded in so the handshake is closed while held in reset.
    assign in_ready = rst_n && (r_state == ROW_ISSUE);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state != ROW_ISSUE) || (r_row_cnt != 3'd0);

    // The tail tag lines up with eng_x_out for the same operation.
    assign w_tail      = r_tag[DCT_LAT-1];
    assign w_wb_en     = w_tail.vld && (w_tail.pass == PASS_ROW);
    assign w_emit      = w_tail.vld && (w_tail.pass == PASS_COL);
    assign w_row7_done = w_wb_en && (w_tail.idx == 3'd7);

    always_comb begin
        eng_x_in = '0;
        w_tag_in = '0;
        if (w_accept) begin
            eng_x_in = in_data;
            w_tag_in = '{vld: 1'b1, pass: PASS_ROW, idx: r_row_cnt};
        end else if (r_state == COL_ISSUE) begin
            eng_x_in = w_col_rd;
            w_tag_in = '{vld: 1'b1, pass: PASS_COL, idx: r_col_cnt};
        end
    end

    dct_tbuf #(.W(W)) u_tbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wb_en),
        .i_wr_row  (w_tail.idx),
        .i_wr_data (eng_x_out),
        .i_rd_col  (r_col_cnt),
        .o_rd_data (w_col_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DCT_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int unsigned i = 1; i < DCT_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ROW_ISSUE;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
        end else begin
            case (r_state)
                ROW_ISSUE: begin
                    if (w_accept) begin
                        r_row_cnt <= r_row_cnt + 3'd1;
                        if (r_row_cnt == 3'd7) begin
                            r_state <= ROW_DRAIN;
                        end
                    end
                end
                ROW_DRAIN: begin
                    // Row 7 is written back on this edge, so column 0 reads a full buffer next cycle.
                    if (w_row7_done) begin
                        r_state <= COL_ISSUE;
                    end
                end
                COL_ISSUE: begin
                    r_col_cnt <= r_col_cnt + 3'd1;
                    if (r_col_cnt == 3'd7) begin
                        r_state <= ROW_ISSUE;
                    end
                end
                default: r_state <= ROW_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_col   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_out_last  <= w_emit && (w_tail.idx == 3'd7);
            if (w_emit) begin
                r_out_data <= eng_x_out;
                r_out_col  <= w_tail.idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_col   = r_out_col;
    assign out_last  = r_out_last;

`ifdef DCT_2D_BLK_CNT_EN
    logic [15:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt <= '0;
        end else if (r_out_valid && r_out_last) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule
